// File: rtl/fir_decim_buf.sv
// -----------------------------------------------------------------------------
// fir_decim_buf
//
// Downstream stage of the pipelined FIR filter. Takes the FIR output stream,
// decimates it by DECIM = 2**LOG2D using a boxcar average, and parks each
// averaged result in a small show-ahead FIFO. A slower consumer such as a UART
// or DMA engine drains the FIFO through a valid/ready handshake.
//
// If a result completes while the FIFO is full and nothing is leaving on that
// edge, the result is dropped and the sticky overflow flag is raised. The flag
// stays set until reset_p.
//
// Parameters
//   WIDTH  sample width, unsigned (matches FIR y)
//   LOG2D  log2 of the decimation factor (1..4, i.e. DECIM 2..16)
//   AW     FIFO address width, DEPTH = 2**AW entries
//
// Ports
//   clk        single clock, all state changes on the rising edge
//   reset_p    synchronous, active-high reset
//   in_en      y_in carries a valid new sample this cycle
//   y_in       FIR output sample
//   out_data   head-of-FIFO averaged sample, 0 while the FIFO is empty
//   out_valid  FIFO is non-empty
//   out_ready  consumer takes out_data on an edge where out_valid is high
//   count      FIFO occupancy, 0..DEPTH
//   overflow   sticky: at least one result was dropped on a full FIFO
// -----------------------------------------------------------------------------
module fir_decim_buf #(
  parameter int WIDTH = 16,
  parameter int LOG2D = 2,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic             in_en,
  input  logic [WIDTH-1:0] y_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW:0]      count,
  output logic             overflow
);

  // The accumulator carries LOG2D guard bits, so a full group of
  // maximum-valued samples cannot wrap.
  localparam int ACCW  = WIDTH + LOG2D;
  localparam int DEPTH = 1 << AW;

  // ---------------------------------------------------------------------------
  // Boxcar accumulator
  // ---------------------------------------------------------------------------
  logic [LOG2D-1:0] phase;
  logic [ACCW-1:0]  acc;
  logic [ACCW-1:0]  acc_sum;
  logic [WIDTH-1:0] result;
  logic             group_done;

  assign acc_sum = acc + ACCW'(y_in);

  // Dividing by DECIM is a truncating right shift. The remaining upper bits
  // are exactly WIDTH wide.
  assign result = acc_sum[ACCW-1:LOG2D];

  // phase counts 0..DECIM-1 in LOG2D bits, so the last sample of a group is
  // the one seen while every phase bit is set.
  assign group_done = in_en && (&phase);

  // NOTE: sequential state uses non-blocking assignments, so every register
  // here samples the pre-edge values of the others, as real flops do.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      acc   <= '0;
      phase <= '0;
    end else if (in_en) begin
      if (&phase) begin
        acc   <= '0;
        phase <= '0;
      end else begin
        acc   <= acc_sum;
        phase <= phase + LOG2D'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Show-ahead FIFO
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             empty;
  logic             pop;
  logic             wr_en;
  logic             drop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // A pop request on an empty FIFO is simply ignored. count cannot underflow.
  assign pop = out_ready && !empty;

  // A full FIFO still accepts a result on an edge that also pops. The freed
  // slot and the new write balance out.
  assign wr_en = group_done && (!full || pop);
  assign drop  = group_done && full && !pop;

  always_ff @(posedge clk) begin
    if (reset_p) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      // Pointers are exactly AW bits wide, so they wrap modulo DEPTH.
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);

      case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase

      if (drop) overflow <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset. Entries are only read once count
  // says they were written, so clearing them would only cost reset fan-out.
  // Writes are still gated by reset_p so that reset wins over a
  // simultaneous push.
  always_ff @(posedge clk) begin
    if (wr_en && !reset_p) mem[wr_ptr] <= result;
  end

  assign out_valid = !empty;

  // NOTE: out_data gets a default before the conditional. Every path through
  // the block then assigns it, so no latch is inferred.
  always_comb begin
    out_data = '0;
    if (!empty) out_data = mem[rd_ptr];
  end

endmodule

// File: tb/tb_fir_decim_buf.sv
// -----------------------------------------------------------------------------
// tb_fir_decim_buf
//
// Self-checking bench for fir_decim_buf with LOG2D=2 and AW=3.
//
// A reference model, built only from the stimulus the bench drives, predicts
// the averaged results and pushes them onto exp_q. Whenever the handshake
// completes, the DUT's head value is compared with the front of exp_q.
// Occupancy, valid, head and the sticky overflow flag are also checked against
// the model after every edge, along with scenario-specific constants.
// -----------------------------------------------------------------------------
module tb_fir_decim_buf;

  localparam int WIDTH = 16;
  localparam int LOG2D = 2;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int DECIM = 4;

  logic             clk = 1'b0;
  logic             reset_p;
  logic             in_en;
  logic [WIDTH-1:0] y_in;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [AW:0]      count;
  logic             overflow;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [WIDTH-1:0] exp_q[$];
  int               m_acc;
  int               m_phase;
  bit               m_ovf;

  // Handshake observed on the most recent edge.
  bit               had_pop;        // model expected a pop
  logic [WIDTH-1:0] pop_exp;        // value the model expected to leave
  bit               pop_dut_valid;  // DUT had out_valid & out_ready before the edge
  logic [WIDTH-1:0] pop_got;        // DUT out_data before the edge

  fir_decim_buf #(.WIDTH(WIDTH), .LOG2D(LOG2D), .AW(AW)) dut (
    .clk      (clk),
    .reset_p  (reset_p),
    .in_en    (in_en),
    .y_in     (y_in),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] exp_head();
    return (exp_q.size() != 0) ? exp_q[0] : '0;
  endfunction

  // Drives one cycle of stimulus, captures the pre-edge handshake, then
  // advances the model past the edge. Returns at posedge+1.
  task automatic step(input bit en, input logic [WIDTH-1:0] y, input bit rdy);
    int               sum;
    bit               push;
    bit               mpop;
    logic [WIDTH-1:0] res;
    reset_p   = 1'b0;
    in_en     = en;
    y_in      = y;
    out_ready = rdy;
    @(negedge clk);
    pop_dut_valid = out_valid && out_ready;
    pop_got       = out_data;
    @(posedge clk);
    #1;
    mpop = rdy && (exp_q.size() != 0);
    push = 1'b0;
    res  = '0;
    if (en) begin
      sum = m_acc + int'(y);
      if (m_phase == DECIM - 1) begin
        push    = 1'b1;
        res     = WIDTH'(sum / DECIM);
        m_acc   = 0;
        m_phase = 0;
      end else begin
        m_acc   = sum;
        m_phase = m_phase + 1;
      end
    end
    had_pop = mpop;
    pop_exp = mpop ? exp_q[0] : '0;
    if (push) begin
      if (exp_q.size() == DEPTH && !mpop) m_ovf = 1'b1;
      else exp_q.push_back(res);
    end
    if (mpop) void'(exp_q.pop_front());
  endtask

  // Holds reset for two edges while in_en and out_ready are active.
  // Reset must take priority over both.
  task automatic apply_reset();
    reset_p   = 1'b1;
    in_en     = 1'b1;
    y_in      = 16'd999;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_p = 1'b0;
    in_en   = 1'b0;
    exp_q.delete();
    m_acc   = 0;
    m_phase = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (count !== 4'd0 || out_valid !== 1'b0 || out_data !== 16'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: count=%0d valid=%0b data=%0d ovf=%0b, need 0/0/0/0",
               count, out_valid, out_data, overflow);
    end
  endtask

  task automatic test_stream();
    logic [WIDTH-1:0] pat [4] = '{16'd100, 16'd200, 16'd300, 16'd400};
    int pops = 0;
    apply_reset();
    for (int i = 0; i < 24; i++) begin
      step(1'b1, pat[i % 4], 1'b1);
      if (pop_dut_valid) pops++;
      checks++;
      if (pop_dut_valid !== had_pop || (had_pop && pop_got !== pop_exp)
          || (had_pop && pop_got !== 16'd250)) begin
        errors++;
        $display("FAIL stream_pop[%0d]: dut pop=%0b data=%0d, need pop=%0b data=%0d (250)",
                 i, pop_dut_valid, pop_got, had_pop, pop_exp);
      end
      checks++;
      if (count > 4'd1 || count !== 4'(exp_q.size()) || out_valid !== (exp_q.size() != 0)
          || out_data !== exp_head()) begin
        errors++;
        $display("FAIL stream_state[%0d]: count=%0d valid=%0b data=%0d, need count=%0d (<=1) data=%0d",
                 i, count, out_valid, out_data, exp_q.size(), exp_head());
      end
    end
    // Six results, each popped on the cycle after it lands, except the last.
    checks++;
    if (pops != 5 || count !== 4'd1) begin
      errors++;
      $display("FAIL stream_total: pops=%0d count=%0d, need pops=5 count=1", pops, count);
    end
  endtask

  task automatic test_overflow();
    logic [WIDTH-1:0] pat [4] = '{16'd100, 16'd200, 16'd300, 16'd400};
    apply_reset();
    for (int i = 1; i <= 40; i++) begin
      step(1'b1, pat[(i - 1) % 4], 1'b0);
      checks++;
      if (count !== 4'(exp_q.size()) || overflow !== m_ovf || out_data !== exp_head()) begin
        errors++;
        $display("FAIL ovf_state[%0d]: count=%0d ovf=%0b data=%0d, need %0d/%0b/%0d",
                 i, count, overflow, out_data, exp_q.size(), m_ovf, exp_head());
      end
      if (i == 32) begin
        checks++;
        if (count !== 4'd8 || overflow !== 1'b0) begin
          errors++;
          $display("FAIL ovf_full32: count=%0d ovf=%0b, need count=8 ovf=0", count, overflow);
        end
      end
      if (i == 36) begin
        checks++;
        if (count !== 4'd8 || overflow !== 1'b1) begin
          errors++;
          $display("FAIL ovf_drop36: count=%0d ovf=%0b, need count=8 ovf=1", count, overflow);
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 16'd0, 1'b1);
      checks++;
      if (!pop_dut_valid || pop_got !== 16'd250 || pop_got !== pop_exp) begin
        errors++;
        $display("FAIL ovf_drain[%0d]: pop=%0b data=%0d, need pop=1 data=250", i, pop_dut_valid, pop_got);
      end
    end
    checks++;
    if (count !== 4'd0 || out_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_after_drain: count=%0d valid=%0b ovf=%0b, need 0/0/1", count, out_valid, overflow);
    end
  endtask

  task automatic test_full_push_pop();
    apply_reset();
    for (int g = 0; g < 8; g++)
      for (int s = 0; s < 4; s++)
        step(1'b1, WIDTH'(8 * (g + 1)), 1'b0);
    for (int s = 0; s < 3; s++) step(1'b1, 16'd72, 1'b0);
    step(1'b1, 16'd72, 1'b1);
    checks++;
    if (count !== 4'd8 || overflow !== 1'b0 || out_data !== 16'd16 || pop_got !== 16'd8
        || !pop_dut_valid) begin
      errors++;
      $display("FAIL full_push_pop: count=%0d ovf=%0b head=%0d popped=%0d, need 8/0/16/8",
               count, overflow, out_data, pop_got);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 16'd0, 1'b1);
      checks++;
      if (!pop_dut_valid || pop_got !== pop_exp || pop_got !== WIDTH'(16 + 8 * i)) begin
        errors++;
        $display("FAIL full_drain[%0d]: pop=%0b data=%0d, need data=%0d",
                 i, pop_dut_valid, pop_got, 16 + 8 * i);
      end
    end
    checks++;
    if (count !== 4'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_empty_end: count=%0d valid=%0b, need 0/0", count, out_valid);
    end
  endtask

  task automatic test_gapped();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      step((i % 3) == 0, 16'hFFFF, 1'b0);
      if (i == 8) begin
        checks++;
        if (count !== 4'd0 || out_valid !== 1'b0) begin
          errors++;
          $display("FAIL gapped_early: count=%0d valid=%0b, need 0/0", count, out_valid);
        end
      end
    end
    checks++;
    if (count !== 4'd1 || out_valid !== 1'b1 || out_data !== 16'hFFFF || out_data !== exp_head()) begin
      errors++;
      $display("FAIL gapped_result: count=%0d valid=%0b data=%h, need 1/1/ffff", count, out_valid, out_data);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    // Force a drop so the reset has a sticky flag and a full FIFO to clear.
    for (int i = 0; i < 36; i++) step(1'b1, 16'd10, 1'b0);
    step(1'b1, 16'd500, 1'b0);
    step(1'b1, 16'd500, 1'b0);
    apply_reset();
    checks++;
    if (count !== 4'd0 || overflow !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'd0) begin
      errors++;
      $display("FAIL midreset_state: count=%0d ovf=%0b valid=%0b data=%0d, need all 0",
               count, overflow, out_valid, out_data);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 16'd40, 1'b0);
    checks++;
    if (count !== 4'd1 || out_data !== 16'd40 || out_data !== exp_head()) begin
      errors++;
      $display("FAIL midreset_first: count=%0d data=%0d, need count=1 data=40", count, out_data);
    end
  endtask

  task automatic test_empty_ready();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 16'h1234, 1'b1);
      checks++;
      if (count !== 4'd0 || out_valid !== 1'b0 || out_data !== 16'd0 || pop_dut_valid) begin
        errors++;
        $display("FAIL empty_ready[%0d]: count=%0d valid=%0b data=%0d, need 0/0/0",
                 i, count, out_valid, out_data);
      end
    end
  endtask

  initial begin
    reset_p   = 1'b1;
    in_en     = 1'b0;
    y_in      = '0;
    out_ready = 1'b0;
    m_acc     = 0;
    m_phase   = 0;
    m_ovf     = 1'b0;
    test_reset();
    test_stream();
    test_overflow();
    test_full_push_pop();
    test_gapped();
    test_reset_mid();
    test_empty_ready();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
